// File: rtl/cmos_capture_16b.sv
// ============================================================================
// cmos_capture_16b
// ----------------------------------------------------------------------------
// Captures frames from an 8-bit CMOS sensor bus and packs each pair of bytes
// into one 16-bit RGB565 pixel. The high byte of a pixel arrives first.
//
// After reset, the first SKIP_FRAMES frames are thrown away while the sensor
// settles. After that, each vsync rising edge starts a captured frame.
// A captured frame is IMG_ROW lines of IMG_COL pixels each. Line-length
// errors, overlong lines and frames cut short by an early vsync set a sticky
// error flag. Only frames with no error advance the good-frame counter.
//
// Ports
//   cmos_pclk        in   1  pixel clock, sole clock, rising edge
//   rst_n            in   1  asynchronous active-low reset
//   cmos_vsync       in   1  frame sync, rising edge marks frame start
//   cmos_href        in   1  line valid, high while active bytes are on the bus
//   cmos_data        in   8  sensor byte bus
//   data_16b         out 16  packed pixel {first byte, second byte}
//   data_16b_en      out  1  one-cycle strobe qualifying data_16b
//   cmos_data_valid  out  1  high for the whole captured frame
//   frame_cnt        out  8  number of completed good frames, wraps 255->0
//   frame_err        out  1  sticky error for the current / most recent frame
// ============================================================================
module cmos_capture_16b #(
    parameter int IMG_ROW     = 8,
    parameter int IMG_COL     = 512,
    parameter int SKIP_FRAMES = 10
) (
    input  logic        cmos_pclk,
    input  logic        rst_n,
    input  logic        cmos_vsync,
    input  logic        cmos_href,
    input  logic [7:0]  cmos_data,
    output logic [15:0] data_16b,
    output logic        data_16b_en,
    output logic        cmos_data_valid,
    output logic [7:0]  frame_cnt,
    output logic        frame_err
);

    // Counter widths. Each counter can hold its terminal value:
    //   - the pixel counter can hold IMG_COL
    //   - the line counter can hold IMG_ROW
    // The skip counter keeps at least one bit, so SKIP_FRAMES=0 still elaborates.
    localparam int PIX_W     = $clog2(IMG_COL + 1);
    localparam int LINE_W    = $clog2(IMG_ROW + 1);
    localparam int SKIP_W    = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
    localparam int SKIP_LAST = (SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0;

    typedef enum logic [1:0] {
        ST_SKIP    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_FRAME   = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Input synchronisation stages
    logic        vs_d1_q, vs_d2_q;
    logic        href_d1_q, href_d2_q;
    logic [7:0]  data_d1_q;

    // Capture datapath state
    logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
    logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
    logic              phase_q, phase_d;
    logic [7:0]        high_byte_q, high_byte_d;
    logic              ignore_q, ignore_d;
    logic [15:0]       data_16b_q, data_16b_d;
    logic              data_en_q, data_en_d;
    logic              valid_q, valid_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              frame_err_q, frame_err_d;

    // Decoded events
    logic vs_rise;
    logic href_fall;
    logic in_frame;
    logic frame_start;
    logic line_act;
    logic byte_act;
    logic fall_act;
    logic pix_full;
    logic line_bad;
    logic last_line;
    logic early_vs;
    logic emit;
    logic overflow;

    // Register the sensor pins once.
    // vsync and href are also delayed by a second stage so that edges can be
    // detected. Only registered copies feed the rest of the logic.
    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d1_q   <= 1'b0;
            vs_d2_q   <= 1'b0;
            href_d1_q <= 1'b0;
            href_d2_q <= 1'b0;
            data_d1_q <= 8'd0;
        end else begin
            vs_d1_q   <= cmos_vsync;
            vs_d2_q   <= vs_d1_q;
            href_d1_q <= cmos_href;
            href_d2_q <= href_d1_q;
            data_d1_q <= cmos_data;
        end
    end

    // Edge and qualification decode.
    // ignore_q masks a line that was already in progress when the frame began.
    // pix_full means the line already holds IMG_COL pixels, so any further
    // pixel is an overflow and is dropped.
    always_comb begin
        vs_rise     = vs_d1_q & ~vs_d2_q;
        href_fall   = ~href_d1_q & href_d2_q;
        in_frame    = (state_q == ST_FRAME);
        frame_start = (state_q == ST_WAIT_VS) & vs_rise;
        line_act    = in_frame & ~ignore_q;
        byte_act    = line_act & href_d1_q;
        fall_act    = line_act & href_fall;
        pix_full    = (pix_cnt_q == PIX_W'(IMG_COL));
        line_bad    = fall_act & (~pix_full | phase_q);
        last_line   = fall_act & (line_cnt_q == LINE_W'(IMG_ROW - 1));
        early_vs    = in_frame & vs_rise & ~last_line;
        emit        = byte_act & phase_q & ~pix_full;
        overflow    = byte_act & phase_q & pix_full;
    end

    // FSM state register
    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_SKIP;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    // If the last line finishes in the same cycle as a vsync edge arrives,
    // the frame counts as completed and the edge is ignored.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_SKIP: begin
                if (SKIP_FRAMES == 0) begin
                    state_d = ST_WAIT_VS;
                end else if (vs_rise && (skip_cnt_q == SKIP_W'(SKIP_LAST))) begin
                    state_d = ST_WAIT_VS;
                end
            end
            ST_WAIT_VS: begin
                if (vs_rise) begin
                    state_d = ST_FRAME;
                end
            end
            ST_FRAME: begin
                if (last_line || early_vs) begin
                    state_d = ST_WAIT_VS;
                end
            end
            default: begin
                state_d = ST_SKIP;
            end
        endcase
    end

    // FSM output logic.
    // The frame-valid flag follows the current state and is registered.
    // Because it is registered, it always falls for at least one cycle
    // between frames.
    always_comb begin
        valid_d = (state_q == ST_FRAME);
    end

    // Datapath next-state logic.
    //
    // Byte phase:
    //   - alternates high/low on each active byte
    //   - returns to 0 whenever href drops
    //
    // End of line (href fall):
    //   - the pixel count is checked against IMG_COL
    //   - an odd leftover byte (phase still 1) is also flagged as an error
    //
    // A new frame clears the per-frame counters and the error flag.
    always_comb begin
        skip_cnt_d  = skip_cnt_q;
        pix_cnt_d   = pix_cnt_q;
        line_cnt_d  = line_cnt_q;
        high_byte_d = high_byte_q;
        data_16b_d  = data_16b_q;
        frame_cnt_d = frame_cnt_q;
        frame_err_d = frame_err_q | line_bad | overflow | early_vs;
        phase_d     = byte_act ? ~phase_q : 1'b0;
        ignore_d    = frame_start ? href_d1_q : (ignore_q & href_d1_q);
        data_en_d   = emit;

        if ((state_q == ST_SKIP) && vs_rise) begin
            skip_cnt_d = skip_cnt_q + SKIP_W'(1);
        end

        if (byte_act && !phase_q) begin
            high_byte_d = data_d1_q;
        end

        if (emit) begin
            data_16b_d = {high_byte_q, data_d1_q};
        end

        if (frame_start) begin
            pix_cnt_d   = '0;
            line_cnt_d  = '0;
            frame_err_d = 1'b0;
        end else if (fall_act) begin
            pix_cnt_d  = '0;
            line_cnt_d = line_cnt_q + LINE_W'(1);
        end else if (emit) begin
            pix_cnt_d = pix_cnt_q + PIX_W'(1);
        end

        if (last_line && !frame_err_q && !line_bad) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    // Datapath registers.
    // An asynchronous reset clears every output, even in the middle of a frame.
    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
            skip_cnt_q  <= '0;
            pix_cnt_q   <= '0;
            line_cnt_q  <= '0;
            phase_q     <= 1'b0;
            high_byte_q <= 8'd0;
            ignore_q    <= 1'b0;
            data_16b_q  <= 16'd0;
            data_en_q   <= 1'b0;
            valid_q     <= 1'b0;
            frame_cnt_q <= 8'd0;
            frame_err_q <= 1'b0;
        end else begin
            skip_cnt_q  <= skip_cnt_d;
            pix_cnt_q   <= pix_cnt_d;
            line_cnt_q  <= line_cnt_d;
            phase_q     <= phase_d;
            high_byte_q <= high_byte_d;
            ignore_q    <= ignore_d;
            data_16b_q  <= data_16b_d;
            data_en_q   <= data_en_d;
            valid_q     <= valid_d;
            frame_cnt_q <= frame_cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign data_16b        = data_16b_q;
    assign data_16b_en     = data_en_q;
    assign cmos_data_valid = valid_q;
    assign frame_cnt       = frame_cnt_q;
    assign frame_err       = frame_err_q;

endmodule

// File: tb/tb_cmos_capture_16b.sv
// ============================================================================
// tb_cmos_capture_16b
// ----------------------------------------------------------------------------
// Directed testbench for cmos_capture_16b.
//
// Expected values are computed in the bench:
//   - each expected pixel, with the cycle its strobe should appear, goes into
//     a pixel queue
//   - each expected frame-valid rising edge goes into a separate queue
// A monitor on the falling clock edge checks every strobe and every valid
// rise against these queues. Status flags are checked directly at chosen
// points in the sequence.
// ============================================================================
module tb_cmos_capture_16b;

    localparam int IMG_ROW     = 8;
    localparam int IMG_COL     = 512;
    localparam int SKIP_FRAMES = 2;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        vsync;
    logic        href;
    logic [7:0]  din;
    logic [15:0] data_16b;
    logic        data_16b_en;
    logic        cmos_data_valid;
    logic [7:0]  frame_cnt;
    logic        frame_err;

    int   cyc;
    int   checks;
    int   errors;
    exp_t pxq[$];
    int   vq[$];
    logic prevValid;

    cmos_capture_16b #(
        .IMG_ROW    (IMG_ROW),
        .IMG_COL    (IMG_COL),
        .SKIP_FRAMES(SKIP_FRAMES)
    ) dut (
        .cmos_pclk      (clk),
        .rst_n          (rst_n),
        .cmos_vsync     (vsync),
        .cmos_href      (href),
        .cmos_data      (din),
        .data_16b       (data_16b),
        .data_16b_en    (data_16b_en),
        .cmos_data_valid(cmos_data_valid),
        .frame_cnt      (frame_cnt),
        .frame_err      (frame_err)
    );

    // Free-running clock, with a cycle index advanced on every rising edge
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pixel value for frame f, line l, column c.
    // The very first captured pixel is fixed at 0xABCD.
    function automatic logic [15:0] pix(input int f, input int l, input int c);
        int v;
        if (f == 0 && l == 0 && c == 0) begin
            return 16'hABCD;
        end
        v = (f * 4099 + l * 613 + c * 37 + 5) ^ 16'h96E1;
        return v[15:0];
    endfunction

    // Drive one cycle of sensor inputs, just after the rising edge
    task automatic applyStimulus(input logic vs, input logic hr, input logic [7:0] d);
        @(posedge clk);
        #1;
        vsync = vs;
        href  = hr;
        din   = d;
    endtask

    // Compare one observed value with its expected value
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %0h want %0h", name, actual, expected);
        end
    endtask

    // Drive one vsync pulse.
    // If it should start a frame, queue the expected valid-rise cycle,
    // which is three cycles after the pin change.
    task automatic sendVsync(input bit startsFrame);
        applyStimulus(1'b1, 1'b0, 8'h00);
        if (startsFrame) vq.push_back(cyc + 3);
        repeat (3) applyStimulus(1'b1, 1'b0, 8'h00);
        repeat (6) applyStimulus(1'b0, 1'b0, 8'h00);
    endtask

    // Drive one line of nBytes bytes, then an idle gap.
    // Each in-range pixel is queued to strobe two cycles after its low byte.
    task automatic sendLine(input int f, input int l, input int nBytes);
        logic [15:0] p;
        exp_t        e;
        for (int b = 0; b < nBytes; b++) begin
            p = pix(f, l, b / 2);
            applyStimulus(1'b0, 1'b1, b[0] ? p[7:0] : p[15:8]);
            if (b[0] && (b / 2) < IMG_COL) begin
                e.data = p;
                e.cyc  = cyc + 2;
                pxq.push_back(e);
            end
        end
        repeat (8) applyStimulus(1'b0, 1'b0, 8'h00);
    endtask

    // Drive nLines lines.
    // Line badLine gets badBytes bytes; every other line is a full line.
    task automatic sendLines(input int f, input int nLines, input int badLine, input int badBytes);
        for (int l = 0; l < nLines; l++) begin
            sendLine(f, l, (l == badLine) ? badBytes : 2 * IMG_COL);
        end
    endtask

    // Monitor: pop and compare every pixel strobe and every frame-valid rise
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && data_16b_en) begin
            checks++;
            if (pxq.size() == 0) begin
                errors++;
                $display("[TB] FAIL pixel unexpected strobe data %h at cycle %0d", data_16b, cyc);
            end else begin
                e = pxq.pop_front();
                if (data_16b !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("[TB] FAIL pixel got %h@%0d want %h@%0d", data_16b, cyc, e.data, e.cyc);
                end
            end
        end
        if (cmos_data_valid && !prevValid) begin
            checks++;
            if (vq.size() == 0) begin
                errors++;
                $display("[TB] FAIL valid_rise unexpected at cycle %0d", cyc);
            end else if (vq[0] != cyc) begin
                errors++;
                $display("[TB] FAIL valid_rise got cycle %0d want %0d", cyc, vq[0]);
                void'(vq.pop_front());
            end else begin
                void'(vq.pop_front());
            end
        end
        prevValid = cmos_data_valid;
    end

    // Watchdog, so a stalled run still ends
    initial begin
        #5ms;
        $display("[TB] FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    // Main directed sequence
    initial begin
        logic [15:0] p;
        exp_t        e;
        int          resetCyc;

        checks    = 0;
        errors    = 0;
        prevValid = 1'b0;
        rst_n     = 1'b0;
        vsync     = 1'b0;
        href      = 1'b0;
        din       = 8'h00;

        // Reset state
        repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("rst_data", data_16b, 0);
        checkOutput("rst_en", data_16b_en, 0);
        checkOutput("rst_valid", cmos_data_valid, 0);
        checkOutput("rst_fcnt", frame_cnt, 0);
        checkOutput("rst_ferr", frame_err, 0);
        rst_n = 1'b1;
        repeat (4) applyStimulus(1'b0, 1'b0, 8'h00);

        // Two settling frames are discarded; the third vsync starts a frame
        sendVsync(1'b0);
        checkOutput("skip1_valid", cmos_data_valid, 0);
        sendVsync(1'b0);
        checkOutput("skip2_valid", cmos_data_valid, 0);
        sendVsync(1'b1);
        sendLines(0, IMG_ROW, -1, 0);
        checkOutput("f0_fcnt", frame_cnt, 1);
        checkOutput("f0_ferr", frame_err, 0);
        checkOutput("f0_valid_low", cmos_data_valid, 0);
        p = pix(0, IMG_ROW - 1, IMG_COL - 1);
        checkOutput("f0_data_hold", data_16b, p);

        // Frame with a 511-pixel line
        sendVsync(1'b1);
        sendLines(1, 4, 3, 2 * IMG_COL - 2);
        checkOutput("f1_ferr_short", frame_err, 1);
        checkOutput("f1_valid_mid", cmos_data_valid, 1);
        sendLines(1, IMG_ROW - 4, -1, 0);
        checkOutput("f1_fcnt", frame_cnt, 1);
        checkOutput("f1_valid_low", cmos_data_valid, 0);

        // Frame with a 1025-byte line: the odd last byte is dropped
        sendVsync(1'b1);
        checkOutput("f2_ferr_clear", frame_err, 0);
        sendLines(2, 3, 2, 2 * IMG_COL + 1);
        checkOutput("f2_ferr_long", frame_err, 1);
        sendLines(2, IMG_ROW - 3, -1, 0);
        checkOutput("f2_fcnt", frame_cnt, 1);

        // Frame cut short by a vsync after 5 lines
        sendVsync(1'b1);
        sendLines(3, 5, -1, 0);
        checkOutput("f3_valid_pre", cmos_data_valid, 1);
        sendVsync(1'b0);
        checkOutput("f3_valid_abort", cmos_data_valid, 0);
        checkOutput("f3_ferr", frame_err, 1);
        checkOutput("f3_fcnt", frame_cnt, 1);

        // The next vsync starts a clean frame
        sendVsync(1'b1);
        sendLines(4, IMG_ROW, -1, 0);
        checkOutput("f4_fcnt", frame_cnt, 2);
        checkOutput("f4_ferr", frame_err, 0);

        // Reset pulsed in the middle of a line
        sendVsync(1'b1);
        for (int b = 0; b < 10; b++) begin
            p = pix(5, 0, b / 2);
            applyStimulus(1'b0, 1'b1, b[0] ? p[7:0] : p[15:8]);
            if (b[0]) begin
                e.data = p;
                e.cyc  = cyc + 2;
                pxq.push_back(e);
            end
        end
        #2;
        rst_n    = 1'b0;
        resetCyc = cyc;
        #1;
        checkOutput("mid_rst_data", data_16b, 0);
        checkOutput("mid_rst_en", data_16b_en, 0);
        checkOutput("mid_rst_valid", cmos_data_valid, 0);
        checkOutput("mid_rst_fcnt", frame_cnt, 0);
        checkOutput("mid_rst_ferr", frame_err, 0);
        // Strobes due at or after the reset cycle will never appear
        while (pxq.size() > 0 && pxq[pxq.size() - 1].cyc >= resetCyc) begin
            void'(pxq.pop_back());
        end
        repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
        rst_n = 1'b1;
        repeat (4) applyStimulus(1'b0, 1'b0, 8'h00);

        // The skip count starts again after reset
        sendVsync(1'b0);
        checkOutput("rskip1_valid", cmos_data_valid, 0);
        sendVsync(1'b0);
        checkOutput("rskip2_valid", cmos_data_valid, 0);
        sendVsync(1'b1);
        checkOutput("rframe_valid", cmos_data_valid, 1);
        checkOutput("rframe_fcnt", frame_cnt, 0);

        repeat (5) applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("pix_queue_empty", pxq.size(), 0);
        checkOutput("valid_queue_empty", vq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
